// File: rtl/arb_mux.sv
// N-channel valid/ready arbiter-mux: fixed-priority, round-robin or forced-select grant
// feeding a one-entry registered output with valid/ready flow control.

module arb_mux_lane #(
    parameter int SW  = 2,
    parameter int IDX = 0
) (
    input  logic          reset_n,
    input  logic          can_load,
    input  logic          gnt_any,
    input  logic [SW-1:0] gnt_idx,
    output logic          d_ready
);
    assign d_ready = reset_n & can_load & gnt_any & (gnt_idx == SW'(IDX));
endmodule

module arb_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int SW   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N*WIDTH-1:0]   d,
    input  logic [N-1:0]         d_valid,
    output logic [N-1:0]         d_ready,
    input  logic [1:0]           mode,
    input  logic [SW-1:0]        sel,
    output logic [WIDTH-1:0]     y,
    output logic [SW-1:0]        y_src,
    output logic                 y_valid,
    input  logic                 y_ready
);
    localparam logic [1:0]    MODE_FIXED = 2'b00;
    localparam logic [1:0]    MODE_FORCE = 2'b10;
    localparam logic [SW-1:0] LAST       = SW'(N - 1);

    logic [N-1:0][WIDTH-1:0] d_arr;
    logic [SW-1:0]           ptr;
    logic [SW-1:0]           gnt_idx;
    logic [SW-1:0]           rr_idx;
    logic                    gnt_any;
    logic                    can_load;
    logic                    xfer;
    logic                    rr_mode;
    int                      rr_j;

    assign d_arr    = d;
    assign can_load = ~y_valid | y_ready;
    assign xfer     = gnt_any & can_load;
    // modes 01 and 11 are both round-robin
    assign rr_mode  = mode[0];

    // Loops run from the far end so the highest-priority candidate is assigned last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        rr_j    = 0;
        case (mode)
            MODE_FIXED: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (d_valid[i]) begin
                        gnt_any = 1'b1;
                        gnt_idx = SW'(i);
                    end
                end
            end
            MODE_FORCE: begin
                if (int'(sel) < N) begin
                    if (d_valid[sel]) begin
                        gnt_any = 1'b1;
                        gnt_idx = sel;
                    end
                end
            end
            default: begin
                for (int k = N - 1; k >= 0; k--) begin
                    rr_j = int'(ptr) + k;
                    if (rr_j >= N) rr_j = rr_j - N;
                    rr_idx = SW'(rr_j);
                    if (d_valid[rr_idx]) begin
                        gnt_any = 1'b1;
                        gnt_idx = rr_idx;
                    end
                end
            end
        endcase
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        arb_mux_lane #(.SW(SW), .IDX(g)) u_lane (
            .reset_n (reset_n),
            .can_load(can_load),
            .gnt_any (gnt_any),
            .gnt_idx (gnt_idx),
            .d_ready (d_ready[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            y       <= '0;
            y_src   <= '0;
            y_valid <= 1'b0;
            ptr     <= '0;
        end else if (xfer) begin
            y       <= d_arr[gnt_idx];
            y_src   <= gnt_idx;
            y_valid <= 1'b1;
            if (rr_mode) ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end else if (y_ready) begin
            // drain only; data and source hold their last values
            y_valid <= 1'b0;
        end
    end
endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel, WIDTH-bit selector that generalises the team's fixed 3:1 combinational mux into a registered, handshaked arbiter-mux. Each cycle it chooses one of N valid/ready input channels under a run-time mode (fixed priority, round-robin or forced select) and captures the winner into a one-entry output register with valid/ready flow control. It sits wherever several producers share one datapath consumer, such as a register-file write port or an ALU operand bus.

## Interface
- WIDTH, 8, data width per channel (>=1)
- N, 4, channel count (>=2)
- SW, $clog2(N), width of source index and forced-select inputs (derived)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  reset, synchronous and active-low
- d  in  N*WIDTH  channel data, channel i at d[i*WIDTH +: WIDTH]
- d_valid  in  N  channel i offers data
- d_ready  out  N  channel i accepted this cycle (at most one bit set)
- mode  in  2  00 fixed priority, 01 round-robin, 10 forced select, 11 same as 01
- sel  in  SW  forced-select channel index (used only in mode 10)
- y  out  WIDTH  registered output data
- y_src  out  SW  channel index that produced y
- y_valid  out  1  output register holds data
- y_ready  in  1  consumer accepts y this cycle

## Operation
- Output register: one entry holding y, y_src and y_valid. It can load when empty (y_valid=0) or when it drains this cycle (y_valid & y_ready).
- Grant (combinational, at most one channel):
  - mode 00: lowest index with d_valid set.
  - mode 01/11: first valid channel searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - mode 10: channel sel if d_valid[sel]. No grant if sel >= N or d_valid[sel]=0.
- d_ready[g] = grant[g] & can_load. Input transfer on channel g when d_valid[g] & d_ready[g]; on the next edge y <= d[g], y_src <= g, y_valid <= 1.
- Drain without a new transfer: y_valid <= 0. y and y_src hold their last values.
- Round-robin pointer ptr (SW bits, values 0..N-1): updates only on an input transfer while mode is 01/11, ptr <= (g==N-1) ? 0 : g+1. It holds in modes 00/10 and is retained across mode changes.
- Mode and sel are sampled combinationally each cycle. Changing them while y_valid=1 never alters the held output.
- Channels not granted see d_ready=0 and must hold their data. The block never drops or duplicates a beat.

## Timing
- Reset (reset_n=0 at an edge): y=0, y_src=0, y_valid=0, ptr=0. d_ready is forced to all zeros while reset_n=0, regardless of inputs.
- Latency: input transfer at edge k gives y_valid=1 with its data after edge k. Minimum one cycle from d_valid to y_valid.
- Throughput: one beat per cycle when y_ready is held high (simultaneous drain and load).
- Backpressure: y_valid=1 and y_ready=0 gives d_ready all zeros. y, y_src and y_valid remain stable until accepted.
- Simultaneous drain and load: the new beat replaces the old one with y_valid staying 1. No bubble.
- Reset mid-operation: reset takes priority over any transfer in the same cycle. A held beat is discarded and ptr returns to 0.
- Wrap-around: after a grant to channel N-1 in round-robin, the search restarts at channel 0.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with all d_valid=1111 -> d_ready=0000, y=0, y_src=0, y_valid=0. Release -> first beat has y_src=0 in mode 01.
- Fixed priority (N=4, W=8): mode=00, d_valid=1010, d1=0x11, d3=0x33, y_ready=1 -> y=0x11, y_src=1 on every beat; channel 3 is starved while channel 1 stays valid.
- Round-robin wrap: mode=01, d_valid=1111, y_ready=1 for 6 cycles -> y_src sequence 0,1,2,3,0,1, one beat per cycle.
- Backpressure: after y_valid=1 with y=0x22, hold y_ready=0 for 3 cycles with d_valid=1111 -> y stays 0x22, d_ready=0000. Raise y_ready -> next beat loads on the same edge that drains.
- Forced select: mode=10, sel=2, d_valid=0111, d2=0xA5 -> y=0xA5, y_src=2. With sel=2 and d_valid=1011 -> no transfer and y_valid falls to 0 after the drain.
- Mid-stream reset plus mode switch: in mode 01 after a grant to channel 1 (ptr=2), pulse reset_n=0 for one cycle -> y_valid=0, ptr=0. Then switch 00->01 with d_valid=1111 -> first grant is channel 0.
